// File: rtl/multi_bank_buffer_pkg.sv
// Shared types and defaults for the N-bank load/compute buffer.
package multi_bank_buf_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 2048;
  localparam int DEFAULT_BUFFER_DEPTH = 16;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/multi_bank_buffer_if.sv
// Loader/compute-side bus of the multi-bank buffer.
// Handshake: wr_en/wr_commit take effect only while load_ready is high and
// rd_en/rd_release only while comp_ready is high; a blocked attempt is dropped
// and raises the sticky ovf_err/udf_err. valid_out qualifies data_out.
interface multi_bank_buffer_if #(
  parameter int DATA_WIDTH = 2048,
  parameter int ADDR_WIDTH = 4,
  parameter int BANK_W     = 1
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_commit;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_release;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  load_ready;
  logic                  comp_ready;
  logic [BANK_W-1:0]     load_bank;
  logic [BANK_W-1:0]     comp_bank;
  logic [BANK_W:0]       full_cnt;
  logic                  ovf_err;
  logic                  udf_err;

  modport master (
    output wr_en, wr_addr, data_in, wr_commit, rd_en, rd_addr, rd_release,
    input  data_out, valid_out, load_ready, comp_ready, load_bank, comp_bank,
           full_cnt, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_addr, data_in, wr_commit, rd_en, rd_addr, rd_release,
    output data_out, valid_out, load_ready, comp_ready, load_bank, comp_bank,
           full_cnt, ovf_err, udf_err
  );
endinterface

// File: rtl/multi_bank_buffer_bank_tracker.sv
// Round-robin load/compute pointers, FULL-bank counter, ready flags and
// sticky overflow/underflow errors for the multi-bank buffer.
module buf_bank_tracker
  import multi_bank_buf_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_commit,
  input  logic              rd_en,
  input  logic              rd_release,
  output logic              wr_ok,
  output logic              rd_ok,
  output logic              load_ready,
  output logic              comp_ready,
  output logic [BANK_W-1:0] load_bank,
  output logic [BANK_W-1:0] comp_bank,
  output logic [BANK_W:0]   full_cnt,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [BANK_W:0] CNT_MAX = (BANK_W+1)'(NUM_BANKS);

  logic        commit_ok;
  logic        release_ok;
  bank_state_t bank_state [NUM_BANKS];

  assign load_ready = (full_cnt < CNT_MAX);
  assign comp_ready = (full_cnt != '0);
  assign wr_ok      = wr_en & load_ready;
  assign commit_ok  = wr_commit & load_ready;
  assign rd_ok      = rd_en & comp_ready;
  assign release_ok = rd_release & comp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_bank <= '0;
      comp_bank <= '0;
      full_cnt  <= '0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else begin
      if (commit_ok)  load_bank <= load_bank + BANK_W'(1);
      if (release_ok) comp_bank <= comp_bank + BANK_W'(1);
      case ({commit_ok, release_ok})
        2'b10:   full_cnt <= full_cnt + (BANK_W+1)'(1);
        2'b01:   full_cnt <= full_cnt - (BANK_W+1)'(1);
        default: full_cnt <= full_cnt;
      endcase
      if ((wr_en | wr_commit) & ~load_ready) ovf_err <= 1'b1;
      if ((rd_en | rd_release) & ~comp_ready) udf_err <= 1'b1;
    end
  end

  // FULL banks are the full_cnt banks starting at comp_bank, in ring order.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_state[i] = BANK_EMPTY;
      if ({1'b0, BANK_W'(i) - comp_bank} < full_cnt) bank_state[i] = BANK_FULL;
    end
  end

  a_cnt_range:  assert property (@(posedge clk) disable iff (rst) full_cnt <= CNT_MAX);
  a_comp_full:  assert property (@(posedge clk) disable iff (rst)
                                 comp_ready |-> bank_state[comp_bank] == BANK_FULL);
  a_load_empty: assert property (@(posedge clk) disable iff (rst)
                                 load_ready |-> bank_state[load_bank] == BANK_EMPTY);

endmodule

// File: rtl/multi_bank_buffer.sv
// N-bank load/compute buffer between the w4a8 loader and the compute array.
// Define MULTI_BANK_BUF_OUT_REG_EN to add a second output register (latency 2).
module multi_bank_buffer
  import multi_bank_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH),
  parameter int NUM_BANKS    = 2
) (
  input logic               clk,
  input logic               rst,
  multi_bank_buffer_if.slave bus
);

  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int MEM_WORDS = NUM_BANKS << ADDR_WIDTH;

  logic                          wr_ok;
  logic                          rd_ok;
  logic [BANK_W-1:0]             load_bank;
  logic [BANK_W-1:0]             comp_bank;
  logic [BANK_W+ADDR_WIDTH-1:0]  wr_idx;
  logic [BANK_W+ADDR_WIDTH-1:0]  rd_idx;
  logic [DATA_WIDTH-1:0]         mem [MEM_WORDS];
  logic                          rd_valid_q;
  logic [DATA_WIDTH-1:0]         rd_data_q;

  buf_bank_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_commit  (bus.wr_commit),
    .rd_en      (bus.rd_en),
    .rd_release (bus.rd_release),
    .wr_ok      (wr_ok),
    .rd_ok      (rd_ok),
    .load_ready (bus.load_ready),
    .comp_ready (bus.comp_ready),
    .load_bank  (load_bank),
    .comp_bank  (comp_bank),
    .full_cnt   (bus.full_cnt),
    .ovf_err    (bus.ovf_err),
    .udf_err    (bus.udf_err)
  );

  assign bus.load_bank = load_bank;
  assign bus.comp_bank = comp_bank;
  // A write alongside a commit uses the pre-commit pointer, so it lands in the committed bank.
  assign wr_idx = {load_bank, bus.wr_addr};
  assign rd_idx = {comp_bank, bus.rd_addr};

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) rd_data_q <= mem[rd_idx];
    end
  end

`ifdef MULTI_BANK_BUF_OUT_REG_EN
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) out_data_q <= rd_data_q;
    end
  end

  assign bus.valid_out = out_valid_q;
  assign bus.data_out  = out_data_q;
`else
  assign bus.valid_out = rd_valid_q;
  assign bus.data_out  = rd_data_q;
`endif

endmodule

// File: tb/tb_multi_bank_buffer.sv
// Drives a 2-bank and a 4-bank buffer with identical vectors and checks both
// against a bank-ring model every cycle, plus hand-computed spot values.
module tb_multi_bank_buffer;
  import multi_bank_buf_pkg::*;

  localparam int DW    = 2048;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef MULTI_BANK_BUF_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0, wr_commit = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] data_in = '0;

  multi_bank_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_W(1)) bus2 ();
  multi_bank_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_W(2)) bus4 ();

  assign bus2.wr_en = wr_en;       assign bus4.wr_en = wr_en;
  assign bus2.wr_addr = wr_addr;   assign bus4.wr_addr = wr_addr;
  assign bus2.data_in = data_in;   assign bus4.data_in = data_in;
  assign bus2.wr_commit = wr_commit; assign bus4.wr_commit = wr_commit;
  assign bus2.rd_en = rd_en;       assign bus4.rd_en = rd_en;
  assign bus2.rd_addr = rd_addr;   assign bus4.rd_addr = rd_addr;
  assign bus2.rd_release = rd_release; assign bus4.rd_release = rd_release;

  multi_bank_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_BANKS(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));
  multi_bank_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_BANKS(4))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%h expected ..%h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  // model: bank ring per DUT (index 0 -> 2 banks, 1 -> 4 banks)
  int            m_ld [2];
  int            m_cp [2];
  int            m_cnt [2];
  bit            m_ovf [2];
  bit            m_udf [2];
  bit            m_v [2];
  logic [DW-1:0] m_dout [2];
  logic [DW-1:0] m_mem [2][4][DEPTH];
  rd_t           exp_q0[$];
  rd_t           exp_q1[$];
  int unsigned   cyc = 0;
  bit            started = 1'b0;

  task automatic model_edge(input int d);
    int  nb;
    bit  lr, cr;
    rd_t r;
    nb = (d == 0) ? 2 : 4;
    m_v[d] = 1'b0;
    if (rst) begin
      m_ld[d] = 0; m_cp[d] = 0; m_cnt[d] = 0;
      m_ovf[d] = 1'b0; m_udf[d] = 1'b0; m_dout[d] = '0;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    lr = (m_cnt[d] < nb);
    cr = (m_cnt[d] > 0);
    if ((wr_en || wr_commit) && !lr) m_ovf[d] = 1'b1;
    if ((rd_en || rd_release) && !cr) m_udf[d] = 1'b1;
    if (rd_en && cr) begin
      r.due  = cyc + LAT - 1;
      r.data = m_mem[d][m_cp[d]][rd_addr];
      if (d == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
    end
    if (wr_en && lr) m_mem[d][m_ld[d]][wr_addr] = data_in;
    if (wr_commit && lr) begin m_ld[d] = (m_ld[d] + 1) % nb; m_cnt[d]++; end
    if (rd_release && cr) begin m_cp[d] = (m_cp[d] + 1) % nb; m_cnt[d]--; end
    if (d == 0) begin
      if (exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
        r = exp_q0.pop_front(); m_v[d] = 1'b1; m_dout[d] = r.data;
      end
    end else begin
      if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
        r = exp_q1.pop_front(); m_v[d] = 1'b1; m_dout[d] = r.data;
      end
    end
  endtask

  task automatic cmp_dut(input int d, input logic v, input logic [DW-1:0] dout,
                         input logic lr, input logic cr, input logic [2:0] lb,
                         input logic [2:0] cb, input logic [2:0] fc,
                         input logic ovf, input logic udf);
    string p;
    int    nb;
    p  = (d == 0) ? "n2" : "n4";
    nb = (d == 0) ? 2 : 4;
    chk({p, ".valid_out"},  64'(v),   64'(m_v[d]));
    chk_data({p, ".data_out"}, dout, m_dout[d]);
    chk({p, ".load_ready"}, 64'(lr),  64'(m_cnt[d] < nb));
    chk({p, ".comp_ready"}, 64'(cr),  64'(m_cnt[d] > 0));
    chk({p, ".load_bank"},  64'(lb),  64'(m_ld[d]));
    chk({p, ".comp_bank"},  64'(cb),  64'(m_cp[d]));
    chk({p, ".full_cnt"},   64'(fc),  64'(m_cnt[d]));
    chk({p, ".ovf_err"},    64'(ovf), 64'(m_ovf[d]));
    chk({p, ".udf_err"},    64'(udf), 64'(m_udf[d]));
  endtask

  // scoreboard: advance model on each edge, compare just after it
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) started = 1'b1;
      if (started) begin
        model_edge(0);
        model_edge(1);
        #1;
        cmp_dut(0, bus2.valid_out, bus2.data_out, bus2.load_ready, bus2.comp_ready,
                {2'b0, bus2.load_bank}, {2'b0, bus2.comp_bank}, {1'b0, bus2.full_cnt},
                bus2.ovf_err, bus2.udf_err);
        cmp_dut(1, bus4.valid_out, bus4.data_out, bus4.load_ready, bus4.comp_ready,
                {1'b0, bus4.load_bank}, {1'b0, bus4.comp_bank}, bus4.full_cnt,
                bus4.ovf_err, bus4.udf_err);
      end
    end
  end

  // driver: inputs change on the falling edge, held across one rising edge
  task automatic do_cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                          input logic cm, input logic re, input logic [AW-1:0] ra,
                          input logic rl);
    wr_en = we; wr_addr = wa; data_in = din; wr_commit = cm;
    rd_en = re; rd_addr = ra; rd_release = rl;
    @(negedge clk);
  endtask

  task automatic idle();
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_5a;

  initial begin
    pat_a5 = {(DW/8){8'hA5}};
    pat_5a = {(DW/8){8'h5A}};
    @(negedge clk);
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    idle();

    chk("lit.rst.load_ready", 64'(bus2.load_ready), 64'd1);
    chk("lit.rst.comp_ready", 64'(bus2.comp_ready), 64'd0);
    chk("lit.rst.full_cnt",   64'(bus2.full_cnt),   64'd0);
    chk("lit.rst.ovf_err",    64'(bus2.ovf_err),    64'd0);
    chk("lit.rst.udf_err",    64'(bus2.udf_err),    64'd0);
    chk_data("lit.rst.data_out", bus2.data_out, '0);

    // write, commit, read back
    do_cycle(1'b1, 4'd3, pat_a5, 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("lit.wr.full_cnt",  64'(bus2.full_cnt),  64'd1);
    chk("lit.wr.load_bank", 64'(bus2.load_bank), 64'd1);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd3, 1'b0);
    repeat (LAT - 1) idle();
    chk("lit.rd.valid_out", 64'(bus2.valid_out), 64'd1);
    chk_data("lit.rd.data_out", bus2.data_out, pat_a5);

    // fill the 2-bank ring, then a blocked write aimed at bank 0 addr 3
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("lit.full.load_ready", 64'(bus2.load_ready), 64'd0);
    chk("lit.full.full_cnt",   64'(bus2.full_cnt),   64'd2);
    do_cycle(1'b1, 4'd3, pat_5a, 1'b0, 1'b0, '0, 1'b0);
    chk("lit.ovf.ovf_err",  64'(bus2.ovf_err),  64'd1);
    chk("lit.ovf.full_cnt", 64'(bus2.full_cnt), 64'd2);
    chk("lit.ovf4.ovf_err", 64'(bus4.ovf_err),  64'd0);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd3, 1'b0);
    repeat (LAT - 1) idle();
    chk_data("lit.ovf.mem_intact", bus2.data_out, pat_a5);

    // commit and release together with one bank full
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    chk("lit.cr.full_cnt",  64'(bus2.full_cnt),  64'd1);
    chk("lit.cr.load_bank", 64'(bus2.load_bank), 64'd1);
    chk("lit.cr.comp_bank", 64'(bus2.comp_bank), 64'd0);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("lit.drain4.full_cnt", 64'(bus4.full_cnt), 64'd0);

    // fill and drain every bank twice
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 4; b++) begin
        do_cycle(1'b1, 4'd0,  rand_word(), 1'b0, 1'b0, '0, 1'b0);
        do_cycle(1'b1, 4'd5,  rand_word(), 1'b0, 1'b0, '0, 1'b0);
        do_cycle(1'b1, 4'd15, rand_word(), 1'b1, 1'b0, '0, 1'b0);
      end
      for (int b = 0; b < 4; b++) begin
        do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd0,  1'b0);
        do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd5,  1'b0);
        do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd15, 1'b1);
      end
    end
    repeat (LAT) idle();
    chk("lit.ring4.load_bank", 64'(bus4.load_bank), 64'd3);
    chk("lit.ring4.comp_bank", 64'(bus4.comp_bank), 64'd3);
    chk("lit.ring4.full_cnt",  64'(bus4.full_cnt),  64'd0);
    chk("lit.ring4.ovf_err",   64'(bus4.ovf_err),   64'd0);
    chk("lit.ring4.udf_err",   64'(bus4.udf_err),   64'd0);

    // read from an empty ring
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b0);
    chk("lit.udf.udf_err", 64'(bus4.udf_err), 64'd1);
    repeat (LAT - 1) idle();
    chk("lit.udf.valid_out", 64'(bus4.valid_out), 64'd0);

    // reset while a read is in flight
    do_cycle(1'b1, 4'd7, rand_word(), 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 4'd7, 1'b0);
    rst = 1'b1;
    idle();
    chk("lit.rst_mid.valid_out", 64'(bus4.valid_out), 64'd0);
    chk("lit.rst_mid.full_cnt",  64'(bus4.full_cnt),  64'd0);
    chk_data("lit.rst_mid.data_out", bus4.data_out, '0);
    rst = 1'b0;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_bank_buffer.md
# multi_bank_buffer

Parametrised N-bank successor to the two-bank load/compute buffer in the w4a8 GEMM datapath. It sits between the weight/activation loader, which writes and commits whole banks, and the compute array, which reads and releases them. Bank handoff is tracked internally with round-robin pointers and an occupancy counter, so the controller no longer drives bank-select bits. The block adds flow control, overflow/underflow protection and an optional output pipeline stage.

## Interface
Parameters:
- DATA_WIDTH, 2048, word width in bits
- BUFFER_DEPTH, 16, words per bank
- ADDR_WIDTH, $clog2(BUFFER_DEPTH), word address width
- NUM_BANKS, 2, bank count, at least 2, power of two
- BANK_W, $clog2(NUM_BANKS), bank index width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write data_in to the load bank at wr_addr
- wr_addr  in  ADDR_WIDTH  word address in the load bank
- data_in  in  DATA_WIDTH  write data
- wr_commit  in  1  marks the load bank FULL and advances the load pointer
- rd_en  in  1  read the compute bank at rd_addr
- rd_addr  in  ADDR_WIDTH  word address in the compute bank
- rd_release  in  1  marks the compute bank EMPTY and advances the compute pointer
- data_out  out  DATA_WIDTH  read data
- valid_out  out  1  data_out valid
- load_ready  out  1  a bank is available for loading (full_cnt < NUM_BANKS)
- comp_ready  out  1  a bank is available for compute (full_cnt > 0)
- load_bank  out  BANK_W  current load pointer
- comp_bank  out  BANK_W  current compute pointer
- full_cnt  out  BANK_W+1  number of FULL banks
- ovf_err  out  1  sticky: write or commit while load_ready was 0
- udf_err  out  1  sticky: read or release while comp_ready was 0

## Operation
- Storage is NUM_BANKS×BUFFER_DEPTH words. The physical address is {bank, addr}.
- A write takes effect only when wr_en and load_ready are both high. A commit takes effect only when wr_commit and load_ready are both high. Commit: load_bank wraps modulo NUM_BANKS and full_cnt increments.
- A read takes effect only when rd_en and comp_ready are both high. A release takes effect only when rd_release and comp_ready are both high. Release: comp_bank wraps and full_cnt decrements.
- Blocked attempts have no effect on storage, pointers or the counter. Each one sets ovf_err or udf_err, which stays set until rst.
- Commit and release in the same cycle: both pointers advance and full_cnt is unchanged.
- A write and a commit in the same cycle: the word lands in the bank being committed.
- Read and write never target the same bank, because load_bank equals comp_bank only when full_cnt is 0 or NUM_BANKS. No read-during-write hazard.
- wr_addr and rd_addr values at or above BUFFER_DEPTH are undefined usage and are not checked.

## Timing
- Reset values: load_bank=0, comp_bank=0, full_cnt=0, valid_out=0, data_out=0, ovf_err=0, udf_err=0. Therefore load_ready=1 and comp_ready=0.
- Memory contents are not reset.
- Reset in mid-operation discards all banks; any in-flight read's valid_out is dropped the next cycle.
- Read latency is 1 cycle: valid_out is asserted in cycle N+1 for an accepted rd_en in cycle N. data_out holds its value when no read is accepted.
- Status outputs are registered-state combinational: they reflect commits and releases from the previous edge.
- A committed bank is readable in the cycle after the commit.

## Configuration
- MULTI_BANK_BUF_OUT_REG_EN defined: adds a second output register. Read latency becomes 2 and valid_out is delayed to match. Reset clears both stages.
- MULTI_BANK_BUF_OUT_REG_EN undefined: latency is 1 as above.

## Structure
- Shared package multi_bank_buf_pkg: the bank state enum (BANK_EMPTY, BANK_FULL), used by assertions and debug, plus the default DATA_WIDTH and BUFFER_DEPTH localparams.
- One sub-module, buf_bank_tracker: holds the pointers, full_cnt, ready flags and sticky errors. Storage and the read pipeline stay in the top module.

## Test plan
- NUM_BANKS=2, after reset: load_ready=1, comp_ready=0, full_cnt=0, all errors 0.
- Write 0xA5.. to addr 3, commit, then rd_en addr 3 -> valid_out and data_out=0xA5.. one cycle later (two cycles with the macro); full_cnt=1, load_bank=1.
- Commit 2 banks -> load_ready=0. A third wr_en -> ovf_err=1, memory unchanged, full_cnt stays 2.
- With full_cnt=1, commit and release in the same cycle -> full_cnt=1, load_bank and comp_bank both advance.
- NUM_BANKS=4: fill and drain 4 banks twice -> pointers wrap 3→0, data per bank intact, no errors.
- rd_en with full_cnt=0 -> udf_err=1, valid_out=0. Assert rst mid-read -> valid_out=0 and full_cnt=0 the next cycle.
